// File: rtl/stride_prefetcher.sv
// Stride data prefetcher: PC-indexed reference prediction table trained on L2 misses,
// feeding an in-order ORB FIFO. Define STRIDE_PF_FILTER_EN to suppress duplicate candidates.
//
// state  | meaning
// INIT   | newly allocated or just mispredicted, stride under test
// TRANS  | stride changed once, waiting for confirmation
// STEADY | stride confirmed, entry may issue prefetches
// NOPRED | stride unstable, no prediction
module stride_prefetcher #(
    parameter int ENTRIES   = 16,
    parameter int ADDR_W    = 32,
    parameter int ORB_DEPTH = 4,
    parameter int DEGREE    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lookup_valid,
    input  logic [ADDR_W-1:0]          lookup_pc,
    input  logic                       train_valid,
    input  logic [ADDR_W-1:0]          train_pc,
    input  logic [ADDR_W-1:0]          train_addr,
    output logic                       pf_valid,
    output logic [ADDR_W-1:0]          pf_addr,
    input  logic                       pf_ready,
    output logic                       pf_drop,
    output logic [$clog2(ORB_DEPTH):0] orb_count
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX - 2;
    localparam int PTR_W = $clog2(ORB_DEPTH);
    localparam logic [ADDR_W-1:0] DEG_V    = ADDR_W'(DEGREE);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(ORB_DEPTH);

    typedef enum logic [1:0] {INIT, TRANS, STEADY, NOPRED} rpt_state_t;

    logic              ent_valid  [ENTRIES];
    logic [TAG_W-1:0]  ent_tag    [ENTRIES];
    logic [ADDR_W-1:0] ent_prev   [ENTRIES];
    logic [ADDR_W-1:0] ent_stride [ENTRIES];
    rpt_state_t        ent_state  [ENTRIES];

    logic [IDX-1:0]    t_idx;
    logic [TAG_W-1:0]  t_tag;
    logic              t_hit;
    logic [ADDR_W-1:0] t_ns;
    logic              t_ok;
    rpt_state_t        nxt_state;
    logic [ADDR_W-1:0] nxt_stride;

    logic [IDX-1:0]    l_idx;
    logic              l_hit;
    logic              cand;
    logic [ADDR_W-1:0] cand_addr;

    logic [ADDR_W-1:0] orb_mem [ORB_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              full;
    logic              pop;
    logic              dup;
    logic              push;
    logic              drop;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], train_pc[1:0]};

    assign t_idx = train_pc[IDX+1:2];
    assign t_tag = train_pc[ADDR_W-1:IDX+2];
    assign t_hit = ent_valid[t_idx] && (ent_tag[t_idx] == t_tag);
    assign t_ns  = train_addr - ent_prev[t_idx];
    assign t_ok  = (t_ns == ent_stride[t_idx]);

    // Table state register: a miss allocates, a hit advances the entry's stride FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i]  <= 1'b0;
                ent_tag[i]    <= '0;
                ent_prev[i]   <= '0;
                ent_stride[i] <= '0;
                ent_state[i]  <= INIT;
            end
        end else if (train_valid) begin
            ent_valid[t_idx]  <= 1'b1;
            ent_tag[t_idx]    <= t_tag;
            ent_prev[t_idx]   <= train_addr;
            ent_stride[t_idx] <= nxt_stride;
            ent_state[t_idx]  <= nxt_state;
        end
    end

    always_comb begin
        nxt_state  = INIT;
        nxt_stride = '0;
        if (t_hit) begin
            nxt_stride = ent_stride[t_idx];
            case (ent_state[t_idx])
                INIT: begin
                    if (t_ok) nxt_state = STEADY;
                    else begin
                        nxt_state  = TRANS;
                        nxt_stride = t_ns;
                    end
                end
                TRANS: begin
                    if (t_ok) nxt_state = STEADY;
                    else begin
                        nxt_state  = NOPRED;
                        nxt_stride = t_ns;
                    end
                end
                STEADY: nxt_state = t_ok ? STEADY : INIT;
                default: begin
                    if (t_ok) nxt_state = TRANS;
                    else begin
                        nxt_state  = NOPRED;
                        nxt_stride = t_ns;
                    end
                end
            endcase
        end
    end

    // Lookup reads registered contents, so a same-cycle train is not yet visible.
    assign l_idx     = lookup_pc[IDX+1:2];
    assign l_hit     = ent_valid[l_idx] && (ent_tag[l_idx] == lookup_pc[ADDR_W-1:IDX+2]);
    assign cand      = lookup_valid && l_hit && (ent_state[l_idx] == STEADY)
                       && (ent_stride[l_idx] != '0);
    assign cand_addr = ent_prev[l_idx] + ent_stride[l_idx] * DEG_V;

    assign pf_valid = (orb_count != '0);
    assign full     = (orb_count == CNT_FULL);
    assign pop      = pf_valid && pf_ready;

`ifdef STRIDE_PF_FILTER_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < ORB_DEPTH; i++) begin
            if (((PTR_W+1)'(i) < orb_count) && (orb_mem[head + PTR_W'(i)] == cand_addr))
                dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign push = cand && !dup && (!full || pop);
    assign drop = cand && !dup && full && !pop;

    always_ff @(posedge clk) begin
        if (push) orb_mem[tail] <= cand_addr;
    end

    // pf_addr is a register tracking the next head so it can hold while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            orb_count <= '0;
            pf_addr   <= '0;
            pf_drop   <= 1'b0;
        end else begin
            pf_drop <= drop;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      orb_count <= orb_count + CNT_ONE;
            else if (pop && !push) orb_count <= orb_count - CNT_ONE;
            if (push && ((orb_count == '0) || (pop && orb_count == CNT_ONE)))
                pf_addr <= cand_addr;
            else if (pop && (orb_count > CNT_ONE))
                pf_addr <= orb_mem[head + 1'b1];
        end
    end
endmodule

// File: doc/stride_prefetcher.md
# stride_prefetcher

Parametrised stride-based data prefetcher: a direct-mapped reference prediction table (RPT) indexed by load PC, trained on L2 data misses and queried on instruction fetch. Confident entries push prefetch addresses into an outstanding request buffer (ORB) FIFO, which issues them to the memory side over a valid/ready handshake. It sits beside the IF stage and the L2 miss path. It generalises the fixed 8-set table to configurable depth, address width and prefetch distance, and adds a queued ORB with back-pressure, explicit reset and drop reporting.

## Interface
- ENTRIES, 16, RPT entries; power of two, ≥2; IDX = $clog2(ENTRIES)
- ADDR_W, 32, PC/data address width
- ORB_DEPTH, 4, ORB FIFO depth; power of two, ≥2
- DEGREE, 1, prefetch distance in strides (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- lookup_valid  in  1  IF presents a new instruction PC
- lookup_pc  in  ADDR_W  IF PC
- train_valid  in  1  single-cycle pulse per L2 data miss
- train_pc  in  ADDR_W  PC of the missing load
- train_addr  in  ADDR_W  data address that missed
- pf_valid  out  1  ORB head valid
- pf_addr  out  ADDR_W  ORB head address
- pf_ready  in  1  memory side accepts head
- pf_drop  out  1  registered pulse: candidate lost because ORB was full
- orb_count  out  $clog2(ORB_DEPTH)+1  ORB occupancy

## Operation
- Index = pc[IDX+1:2]; tag = pc[ADDR_W-1:IDX+2]. Entry fields: valid, tag, prev_addr, stride (ADDR_W, two's complement), state (INIT, TRANS, STEADY, NOPRED).
- Train, tag miss or invalid entry: allocate. valid=1, tag, prev_addr=train_addr, stride=0, state=INIT. Aliasing PCs replace the entry.
- Train, hit: ns = train_addr − prev_addr (mod 2^ADDR_W); ok = (ns == stride); prev_addr ← train_addr always.
  - INIT: ok→STEADY; else TRANS, stride←ns
  - TRANS: ok→STEADY; else NOPRED, stride←ns
  - STEADY: ok→STEADY; else INIT, stride kept
  - NOPRED: ok→TRANS; else NOPRED, stride←ns
- Lookup: the table is read combinationally. A candidate exists when lookup_valid, tag hit, state==STEADY and stride≠0.
  - Candidate address = prev_addr + DEGREE×stride, truncated to ADDR_W. Wrap-around is allowed.
  - If the ORB is not full, push the candidate. If full and no pop occurs this cycle, drop it and pulse pf_drop.
- ORB: in-order FIFO. pf_valid = (orb_count≠0); pf_addr = head. Pop on pf_valid && pf_ready.
  - Push and pop in the same cycle are both accepted, including when full.
  - pf_addr holds its last value while empty.
- Train and lookup in the same cycle, same index: the lookup uses pre-update contents (read-before-write).

## Timing
- Reset values: all entry valid=0, state=INIT; ORB empty; pf_valid=0, pf_addr=0, pf_drop=0, orb_count=0.
- Reset mid-operation clears everything immediately, with no completion of in-flight pushes or pops.
- Train sampled at edge N is visible to a lookup in cycle N+1.
- Lookup at edge N into an empty ORB gives pf_valid=1 with the candidate from cycle N+1. There is no combinational path from lookup to pf_*.
- pf_drop is high for exactly the cycle after the dropping edge.
- pf_addr/pf_valid are stable while pf_valid && !pf_ready.

## Configuration
- STRIDE_PF_FILTER_EN defined: each candidate is compared against every valid ORB entry and against the entry being popped this cycle. A match is discarded silently: no push, no pf_drop.
- Undefined: duplicate addresses are enqueued normally.

## Test plan
- Reset: assert rst mid-stream with orb_count=3 → next cycle pf_valid=0, orb_count=0. Then lookup PC 0x100 → no push.
- Positive stride: train PC 0x100 with 0x1000, 0x1010, 0x1020 (entry INIT→TRANS→STEADY, stride 0x10). Lookup 0x100 → next cycle pf_valid=1, pf_addr=0x1030. With DEGREE=2 → 0x1040.
- Negative stride and wrap: train 0x2000, 0x1FF8, 0x1FF0 → pf_addr 0x1FE8. Train 0x10, 0x8, 0x0 → pf_addr 0xFFFFFFF8.
- Mispredict: after the positive-stride scenario, train 0x1100 → INIT, and a lookup gives no push. Train 0x1110 → STEADY, and a lookup gives pf_addr 0x1120.
- Back-pressure: pf_ready=0, five lookups of a STEADY PC with distinct prev_addr → orb_count=4, pf_drop=1 for one cycle after the 5th. Then pf_ready=1 → four addresses drain in order, one per cycle.
- Filter: two consecutive lookups of the same STEADY PC, pf_ready=0 → orb_count=1 with STRIDE_PF_FILTER_EN, 2 without. pf_drop=0 in both builds.
